// File: rtl/ca_rule_stepper.sv
// Elementary cellular-automaton sequencer: one shared 3-input rule lookup is
// walked across the row one cell per cycle, and each new generation is double-buffered.
module ca_rule_stepper #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic [7:0]       rule,
  input  logic [WIDTH-1:0] seed,
  input  logic [GEN_W-1:0] gens,
  output logic [WIDTH-1:0] row,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EVAL   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       rule_q, rule_d;
  logic [GEN_W-1:0] gens_q, gens_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [WIDTH-1:0] row_q, row_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             done_q, done_d;

  logic [WIDTH+1:0] ext;
  logic [WIDTH+1:0] ext_sh;
  logic [2:0]       nbhd;
  logic             new_bit;
  logic [GEN_W-1:0] gen_inc;

  // Row padded with its boundary neighbours so cell i's {left,center,right} is ext[i+2:i].
  always_comb begin
    ext     = {(WRAP ? row_q[0] : 1'b0), row_q, (WRAP ? row_q[WIDTH-1] : 1'b0)};
    ext_sh  = ext >> idx_q;
    nbhd    = ext_sh[2:0];
    new_bit = rule_q[nbhd];
    gen_inc = gen_q + GEN_W'(1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rule_d  = rule_q;
    gens_d  = gens_q;
    gen_d   = gen_q;
    row_d   = row_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rule_d  = rule;
          gens_d  = gens;
          row_d   = seed;
          gen_d   = '0;
          idx_d   = '0;
          state_d = (gens == '0) ? S_DONE : S_EVAL;
        end
      end
      S_EVAL: begin
        if (!hold) begin
          buf_d = (buf_q & ~(WIDTH'(1) << idx_q)) | (WIDTH'(new_bit) << idx_q);
          if (idx_q == IDX_W'(WIDTH - 1)) state_d = S_COMMIT;
          else                            idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_COMMIT: begin
        if (!hold) begin
          row_d = buf_q;
          gen_d = gen_inc;
          if (gen_inc == gens_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = '0;
            state_d = S_EVAL;
          end
        end
      end
      S_DONE: begin
        // done is registered, so the pulse appears the cycle after DONE while already back in IDLE.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rule_q  <= '0;
      gens_q  <= '0;
      gen_q   <= '0;
      row_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rule_q  <= rule_d;
      gens_q  <= gens_d;
      gen_q   <= gen_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  assign row       = row_q;
  assign gen_count = gen_q;
  assign busy      = (state_q == S_EVAL) || (state_q == S_COMMIT);
  assign done      = done_q;

endmodule

// File: tb/tb_ca_rule_stepper.sv
// Bench for ca_rule_stepper: a wrapping and a non-wrapping instance share stimulus;
// results come from a direct generation-by-generation automaton model.
module tb_ca_rule_stepper;

  localparam int W  = 8;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          reset, start, hold;
  logic [7:0]    rule;
  logic [W-1:0]  seed;
  logic [GW-1:0] gens;
  logic [W-1:0]  row_w, row_n;
  logic [GW-1:0] gc_w, gc_n;
  logic          busy_w, busy_n, done_w, done_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ca_rule_stepper #(.WIDTH(W), .GEN_W(GW), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .rule(rule), .seed(seed),
    .gens(gens), .row(row_w), .gen_count(gc_w), .busy(busy_w), .done(done_w)
  );

  ca_rule_stepper #(.WIDTH(W), .GEN_W(GW), .WRAP(1'b0)) u_nowrap (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .rule(rule), .seed(seed),
    .gens(gens), .row(row_n), .gen_count(gc_n), .busy(busy_n), .done(done_n)
  );

  typedef struct {
    logic [7:0] rule;
    logic [7:0] seed;
    int         gens;
    int         hold_at;
    int         hold_len;
    bit         disturb;
    logic [7:0] exp_w;
    logic [7:0] exp_n;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] r, input logic [7:0] s,
                                       input int n, input bit wrap);
    int cur[W];
    int nxt[W];
    int l, c, rt;
    logic [7:0] res;
    for (int i = 0; i < W; i++) cur[i] = int'(s[i]);
    for (int g = 0; g < n; g++) begin
      for (int i = 0; i < W; i++) begin
        l  = (i == W - 1) ? (wrap ? cur[0] : 0) : cur[i+1];
        rt = (i == 0) ? (wrap ? cur[W-1] : 0) : cur[i-1];
        c  = cur[i];
        nxt[i] = (int'(r) >> (l * 4 + c * 2 + rt)) & 1;
      end
      cur = nxt;
    end
    for (int i = 0; i < W; i++) res[i] = (cur[i] != 0);
    return res;
  endfunction

  task automatic run_case(input string name, input logic [7:0] r, input logic [7:0] s,
                          input int g, input int hold_at, input int hold_len,
                          input bit disturb, input logic [7:0] exp_w, input logic [7:0] exp_n);
    int done_edge;
    int busy_cnt;
    int trace_bad;
    int k;
    int n;
    done_edge = -1;
    busy_cnt  = 0;
    trace_bad = 0;
    @(posedge clk); #1;
    rule = r; seed = s; gens = GW'(g); hold = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done_edge < 0 && k < 400) begin
      if (busy_w) busy_cnt++;
      if (done_w) done_edge = k;
      if (hold_len == 0) begin
        n = k / (W + 1);
        if (n > g) n = g;
        if (row_w !== model(r, s, n, 1'b1) || row_n !== model(r, s, n, 1'b0) ||
            gc_w !== GW'(n)) trace_bad++;
      end
      if (disturb && k == 3) begin
        start = 1'b1; rule = ~r; seed = ~s; gens = GW'(g + 3);
      end
      if (disturb && k == 4) start = 1'b0;
      if (hold_len > 0 && k == hold_at) hold = 1'b1;
      if (hold_len > 0 && k == hold_at + hold_len) hold = 1'b0;
      if (done_edge < 0) begin
        @(posedge clk); #1;
        k++;
      end
    end
    hold = 1'b0; start = 1'b0;
    check({name, " done_edge"}, 64'(done_edge), 64'(g * (W + 1) + 1 + hold_len));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(g * (W + 1) + hold_len));
    check({name, " row_wrap"}, 64'(row_w), 64'(exp_w));
    check({name, " row_nowrap"}, 64'(row_n), 64'(exp_n));
    check({name, " gen_count"}, 64'(gc_w), 64'(g));
    check({name, " gen_count_nowrap"}, 64'(gc_n), 64'(g));
    if (hold_len == 0) check({name, " trace"}, 64'(trace_bad), 64'd0);
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, 64'(done_w), 64'd0);
    check({name, " row_holds"}, 64'(row_w), 64'(exp_w));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r, s;
    int g, ha, hl;

    tbl[0] = '{8'h25, 8'h00, 1, 0, 0, 1'b0, 8'hFF, 8'hFF};
    tbl[1] = '{8'h25, 8'h00, 2, 0, 0, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{8'hF0, 8'h01, 1, 0, 0, 1'b0, 8'h80, 8'h00};
    tbl[3] = '{8'h5A, 8'h08, 1, 0, 0, 1'b1, 8'h14, 8'h14};
    tbl[4] = '{8'h37, 8'hA5, 0, 0, 0, 1'b0, 8'hA5, 8'hA5};
    tbl[5] = '{8'h25, 8'h00, 1, 2, 5, 1'b0, 8'hFF, 8'hFF};

    reset = 1'b1; start = 1'b0; hold = 1'b0; rule = '0; seed = '0; gens = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset row", 64'(row_w), 64'd0);
    check("reset gen_count", 64'(gc_w), 64'd0);
    check("reset busy", 64'(busy_w), 64'd0);
    check("reset done", 64'(done_w), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_case($sformatf("tbl%0d", i), tbl[i].rule, tbl[i].seed, tbl[i].gens,
               tbl[i].hold_at, tbl[i].hold_len, tbl[i].disturb, tbl[i].exp_w, tbl[i].exp_n);

    // Reset in the middle of EVAL, then a fresh run
    @(posedge clk); #1;
    rule = 8'h5A; seed = 8'h08; gens = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun busy_before_reset", 64'(busy_w), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset row", 64'(row_w), 64'd0);
    check("midreset gen_count", 64'(gc_w), 64'd0);
    check("midreset busy", 64'(busy_w), 64'd0);
    check("midreset done", 64'(done_w), 64'd0);
    @(posedge clk); #1;
    check("midreset idle", 64'(busy_w), 64'd0);
    run_case("after_reset", 8'h5A, 8'h08, 1, 0, 0, 1'b0, 8'h14, 8'h14);

    for (int i = 0; i < 10; i++) begin
      r  = 8'($urandom());
      s  = 8'($urandom());
      g  = int'($urandom_range(1, 4));
      ha = int'($urandom_range(1, 5));
      hl = (i % 2 == 0) ? 0 : int'($urandom_range(1, 3));
      run_case($sformatf("rand%0d", i), r, s, g, ha, hl, 1'b0,
               model(r, s, g, 1'b1), model(r, s, g, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
